ntt_result_serializer: RTL and testbench



---
 rtl/ntt_result_serializer.sv | 122 ++++++++++++
 tb/tb_ntt_result_serializer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_result_serializer.sv
// rtl/ntt_result_serializer.sv - captures a 16-lane NTT result block and streams it as OUT_LANES-wide beats
module ntt_result_serializer #(
    parameter int P_WIDTH      = 64,
    parameter int OUT_LANES    = 4,
    parameter int FRAME_BLOCKS = 1024,
    localparam int NBEATS      = 16 / OUT_LANES,
    localparam int BEAT_W      = (NBEATS > 1) ? $clog2(NBEATS) : 1,
    localparam int BLK_W       = (FRAME_BLOCKS > 1) ? $clog2(FRAME_BLOCKS) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [P_WIDTH-1:0]             Result0_in,
    input  logic [P_WIDTH-1:0]             Result1_in,
    input  logic [P_WIDTH-1:0]             Result2_in,
    input  logic [P_WIDTH-1:0]             Result3_in,
    input  logic [P_WIDTH-1:0]             Result4_in,
    input  logic [P_WIDTH-1:0]             Result5_in,
    input  logic [P_WIDTH-1:0]             Result6_in,
    input  logic [P_WIDTH-1:0]             Result7_in,
    input  logic [P_WIDTH-1:0]             Result8_in,
    input  logic [P_WIDTH-1:0]             Result9_in,
    input  logic [P_WIDTH-1:0]             Result10_in,
    input  logic [P_WIDTH-1:0]             Result11_in,
    input  logic [P_WIDTH-1:0]             Result12_in,
    input  logic [P_WIDTH-1:0]             Result13_in,
    input  logic [P_WIDTH-1:0]             Result14_in,
    input  logic [P_WIDTH-1:0]             Result15_in,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [OUT_LANES*P_WIDTH-1:0]   out_data,
    output logic [BEAT_W-1:0]              out_beat,
    output logic                           out_block_last,
    output logic                           out_frame_last,
    output logic [BLK_W-1:0]               blk_cnt
);

    if (OUT_LANES < 1 || OUT_LANES > 16 || (16 % OUT_LANES) != 0) begin : g_bad_lanes
        $error("ntt_result_serializer: OUT_LANES must divide 16");
    end

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);
    localparam logic [BLK_W-1:0]  LAST_BLK  = BLK_W'(FRAME_BLOCKS - 1);

    typedef enum logic {EMPTY, STREAM} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [P_WIDTH-1:0] lanes_in [16];
    logic [P_WIDTH-1:0] hold [16];
    logic [BEAT_W-1:0]  beat;
    logic [3:0]         lane_idx;
    logic               pop;
    logic               last_pop;
    logic               capture;

    assign lanes_in = '{Result0_in,  Result1_in,  Result2_in,  Result3_in,
                        Result4_in,  Result5_in,  Result6_in,  Result7_in,
                        Result8_in,  Result9_in,  Result10_in, Result11_in,
                        Result12_in, Result13_in, Result14_in, Result15_in};

    assign pop      = out_valid && out_ready;
    assign last_pop = pop && out_block_last;
    // Accepting on the final pop lets a new block follow with no bubble.
    assign in_ready = !rst && ((state == EMPTY) || last_pop);
    assign capture  = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (capture) state_nxt = STREAM;
            STREAM:  if (last_pop && !capture) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    // out_data keeps showing the last beat while idle since beat and hold are left untouched.
    always_comb begin
        out_valid      = (state == STREAM);
        out_beat       = beat;
        out_block_last = out_valid && (beat == LAST_BEAT);
        out_frame_last = out_block_last && (blk_cnt == LAST_BLK);
        out_data       = '0;
        lane_idx       = '0;
        for (int j = 0; j < OUT_LANES; j++) begin
            lane_idx = 4'(int'(beat) * OUT_LANES + j);
            out_data[j*P_WIDTH +: P_WIDTH] = hold[lane_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 16; k++) begin
                hold[k] <= '0;
            end
            beat    <= '0;
            blk_cnt <= '0;
        end else begin
            if (capture) begin
                for (int k = 0; k < 16; k++) begin
                    hold[k] <= lanes_in[k];
                end
                beat <= '0;
            end else if (pop && !out_block_last) begin
                beat <= beat + BEAT_W'(1);
            end
            if (last_pop) begin
                blk_cnt <= (blk_cnt == LAST_BLK) ? '0 : blk_cnt + BLK_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ntt_result_serializer.sv
// tb/tb_ntt_result_serializer.sv - randomized bench for ntt_result_serializer against a block-queue model
module tb_ntt_result_serializer;

    localparam int PW = 32;
    localparam int FB = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         iv [2];
    logic         ordy [2];
    logic [511:0] blk_in [2];

    logic         a_in_ready, a_out_valid, a_bl, a_fl;
    logic [127:0] a_out_data;
    logic [1:0]   a_out_beat, a_blk;
    logic         b_in_ready, b_out_valid, b_bl, b_fl;
    logic [511:0] b_out_data;
    logic [0:0]   b_out_beat;
    logic [1:0]   b_blk;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ntt_result_serializer #(.P_WIDTH(PW), .OUT_LANES(4), .FRAME_BLOCKS(FB)) dut_a (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(a_in_ready),
        .Result0_in(blk_in[0][0*PW +: PW]),   .Result1_in(blk_in[0][1*PW +: PW]),
        .Result2_in(blk_in[0][2*PW +: PW]),   .Result3_in(blk_in[0][3*PW +: PW]),
        .Result4_in(blk_in[0][4*PW +: PW]),   .Result5_in(blk_in[0][5*PW +: PW]),
        .Result6_in(blk_in[0][6*PW +: PW]),   .Result7_in(blk_in[0][7*PW +: PW]),
        .Result8_in(blk_in[0][8*PW +: PW]),   .Result9_in(blk_in[0][9*PW +: PW]),
        .Result10_in(blk_in[0][10*PW +: PW]), .Result11_in(blk_in[0][11*PW +: PW]),
        .Result12_in(blk_in[0][12*PW +: PW]), .Result13_in(blk_in[0][13*PW +: PW]),
        .Result14_in(blk_in[0][14*PW +: PW]), .Result15_in(blk_in[0][15*PW +: PW]),
        .out_valid(a_out_valid), .out_ready(ordy[0]), .out_data(a_out_data),
        .out_beat(a_out_beat), .out_block_last(a_bl), .out_frame_last(a_fl), .blk_cnt(a_blk)
    );

    ntt_result_serializer #(.P_WIDTH(PW), .OUT_LANES(16), .FRAME_BLOCKS(FB)) dut_b (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(b_in_ready),
        .Result0_in(blk_in[1][0*PW +: PW]),   .Result1_in(blk_in[1][1*PW +: PW]),
        .Result2_in(blk_in[1][2*PW +: PW]),   .Result3_in(blk_in[1][3*PW +: PW]),
        .Result4_in(blk_in[1][4*PW +: PW]),   .Result5_in(blk_in[1][5*PW +: PW]),
        .Result6_in(blk_in[1][6*PW +: PW]),   .Result7_in(blk_in[1][7*PW +: PW]),
        .Result8_in(blk_in[1][8*PW +: PW]),   .Result9_in(blk_in[1][9*PW +: PW]),
        .Result10_in(blk_in[1][10*PW +: PW]), .Result11_in(blk_in[1][11*PW +: PW]),
        .Result12_in(blk_in[1][12*PW +: PW]), .Result13_in(blk_in[1][13*PW +: PW]),
        .Result14_in(blk_in[1][14*PW +: PW]), .Result15_in(blk_in[1][15*PW +: PW]),
        .out_valid(b_out_valid), .out_ready(ordy[1]), .out_data(b_out_data),
        .out_beat(b_out_beat), .out_block_last(b_bl), .out_frame_last(b_fl), .blk_cnt(b_blk)
    );

    logic [511:0] obs_data [2];
    logic [31:0]  obs_beat [2];
    logic [31:0]  obs_blk [2];
    logic         obs_valid [2];
    logic         obs_bl [2];
    logic         obs_fl [2];
    logic         obs_rdy [2];

    always_comb begin
        obs_data[0] = 512'(a_out_data);  obs_data[1] = b_out_data;
        obs_beat[0] = 32'(a_out_beat);  obs_beat[1] = 32'(b_out_beat);
        obs_blk[0]  = 32'(a_blk);       obs_blk[1]  = 32'(b_blk);
        obs_valid[0] = a_out_valid;     obs_valid[1] = b_out_valid;
        obs_bl[0]   = a_bl;             obs_bl[1]   = b_bl;
        obs_fl[0]   = a_fl;             obs_fl[1]   = b_fl;
        obs_rdy[0]  = a_in_ready;       obs_rdy[1]  = b_in_ready;
    end

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: one pending block per instance; position derived from total beats popped since reset.
    int           nb [2] = '{4, 1};
    int           ol [2] = '{4, 16};
    logic         have [2] = '{1'b0, 1'b0};
    logic [511:0] cur [2];
    logic [511:0] last_d [2] = '{512'd0, 512'd0};
    int           pops [2] = '{0, 0};

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int           b;
            int           bi;
            logic         bl;
            logic         rdy;
            logic [511:0] ed;
            b   = pops[i] % nb[i];
            bi  = (pops[i] / nb[i]) % FB;
            ed  = (cur[i] >> (b * ol[i] * PW)) & ((512'd1 << (ol[i] * PW)) - 512'd1);
            bl  = have[i] && (b == nb[i] - 1);
            rdy = !rst && (!have[i] || (ordy[i] && bl));
            check($sformatf("i%0d_valid", i), 512'(obs_valid[i]), 512'(have[i]));
            if (have[i]) begin
                check($sformatf("i%0d_data", i), obs_data[i], ed);
                check($sformatf("i%0d_beat", i), 512'(obs_beat[i]), 512'(b));
            end else begin
                check($sformatf("i%0d_idle_data", i), obs_data[i], last_d[i]);
            end
            check($sformatf("i%0d_block_last", i), 512'(obs_bl[i]), 512'(bl));
            check($sformatf("i%0d_frame_last", i), 512'(obs_fl[i]), 512'(bl && (bi == FB - 1)));
            check($sformatf("i%0d_blk_cnt", i), 512'(obs_blk[i]), 512'(bi));
            check($sformatf("i%0d_in_ready", i), 512'(obs_rdy[i]), 512'(rdy));
            if (rst) begin
                have[i] = 1'b0; pops[i] = 0; last_d[i] = '0;
            end else begin
                if (have[i] && ordy[i]) begin
                    last_d[i] = ed;
                    pops[i]++;
                    if (bl) have[i] = 1'b0;
                end
                if (iv[i] && rdy) begin
                    cur[i]  = blk_in[i];
                    have[i] = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_blk(input int i);
        for (int k = 0; k < 16; k++) blk_in[i][k*PW +: PW] = $urandom;
    endtask

    initial begin
        int cnt_abl, cnt_afl, cnt_bbl, cnt_bfl;
        logic [511:0] held;
        for (int i = 0; i < 2; i++) begin
            iv[i] = 1'b0; ordy[i] = 1'b1; blk_in[i] = '0;
        end
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("reset_valid", 512'(a_out_valid), 512'd0);
        check("reset_data", 512'(a_out_data), 512'd0);
        check("reset_blk", 512'(a_blk), 512'd0);
        tick();

        // Single block, lanes k+1
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 16; k++) blk_in[i][k*PW +: PW] = PW'(k + 1);
            iv[i] = 1'b1;
        end
        tick();
        iv[0] = 1'b0; iv[1] = 1'b0;
        @(negedge clk);
        check("single_beat0", 512'(a_out_data), 512'(128'h00000004_00000003_00000002_00000001));
        check("single_b_bl", 512'(b_bl), 512'd1);
        repeat (3) tick();
        @(negedge clk);
        check("single_beat3", 512'(a_out_data), 512'(128'h00000010_0000000f_0000000e_0000000d));
        check("single_bl3", 512'(a_bl), 512'd1);
        repeat (4) tick();

        // Back-to-back with changing upstream data
        iv[0] = 1'b1; iv[1] = 1'b1;
        for (int c = 0; c < 9; c++) begin
            rand_blk(0); rand_blk(1);
            tick();
        end
        iv[0] = 1'b0; iv[1] = 1'b0;
        repeat (16) tick();

        // Backpressure at beat 1
        rand_blk(0);
        iv[0] = 1'b1;
        tick();
        iv[0] = 1'b0;
        tick();
        ordy[0] = 1'b0;
        @(negedge clk);
        held = 512'(a_out_data);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("stall_beat", 512'(a_out_beat), 512'd1);
            check("stall_data", 512'(a_out_data), held);
            check("stall_ready", 512'(a_in_ready), 512'd0);
            @(posedge clk);
            #1;
        end
        ordy[0] = 1'b1;
        tick();
        @(negedge clk);
        check("resume_beat2", 512'(a_out_beat), 512'd2);
        repeat (4) tick();

        // Reset during beat 2
        rand_blk(0);
        iv[0] = 1'b1;
        tick();
        iv[0] = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("rst_mid_valid", 512'(a_out_valid), 512'd0);
        check("rst_mid_ready", 512'(a_in_ready), 512'd0);
        tick();
        rst = 1'b0;
        rand_blk(0);
        iv[0] = 1'b1;
        tick();
        iv[0] = 1'b0;
        @(negedge clk);
        check("post_rst_beat", 512'(a_out_beat), 512'd0);
        check("post_rst_blk", 512'(a_blk), 512'd0);
        repeat (6) tick();

        // Frame wrap from a fresh reset: A gets 5 blocks, B gets 17
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cnt_abl = 0; cnt_afl = 0; cnt_bbl = 0; cnt_bfl = 0;
        for (int c = 0; c < 45; c++) begin
            iv[0] = (c < 17); iv[1] = (c < 17);
            rand_blk(0); rand_blk(1);
            @(negedge clk);
            cnt_abl += int'(a_bl); cnt_afl += int'(a_fl);
            cnt_bbl += int'(b_bl); cnt_bfl += int'(b_fl);
            @(posedge clk);
            #1;
        end
        iv[0] = 1'b0; iv[1] = 1'b0;
        check("frame_a_blocks", 512'(cnt_abl), 512'd5);
        check("frame_a_frames", 512'(cnt_afl), 512'd1);
        check("frame_b_blocks", 512'(cnt_bbl), 512'd17);
        check("frame_b_frames", 512'(cnt_bfl), 512'd4);

        // Random traffic with occasional reset
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < 2; i++) begin
                iv[i]   = ($urandom_range(0, 1) == 1);
                ordy[i] = ($urandom_range(0, 9) < 7);
                rand_blk(i);
            end
            tick();
        end
        rst = 1'b0;
        iv[0] = 1'b0; iv[1] = 1'b0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
